// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared types and constants for the vending dispenser: FSM state
//            encoding, coin denomination codes and the code-to-value mapping.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // Product-type width, shared with the sale-side logic
    localparam int c_type_w = 3;

    // Coin denomination codes as driven on coin_code
    localparam logic [1:0] COIN_1  = 2'd0;
    localparam logic [1:0] COIN_5  = 2'd1;
    localparam logic [1:0] COIN_10 = 2'd2;
    localparam logic [1:0] COIN_20 = 2'd3;

    // Dispenser sequencing states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ITEM = 3'd1,
        GAP  = 3'd2,
        COIN = 3'd3,
        DONE = 3'd4,
        JAM  = 3'd5
    } state_t;

    // Money value of a coin code
    function automatic logic [6:0] coin_value(input logic [1:0] code);
        logic [6:0] value;
        case (code)
            COIN_1:  value = 7'd1;
            COIN_5:  value = 7'd5;
            COIN_10: value = 7'd10;
            default: value = 7'd20;
        endcase
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_dispenser_change_picker.sv
`default_nettype none
// ============================================================================
// Module   : change_picker
// Purpose  : Greedy coin selection: largest denomination not exceeding the
//            remaining change. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module change_picker
    import vend_pkg::*;
(
    input  logic [6:0] change,
    output logic [1:0] code,
    output logic [6:0] value
);

    // Pick the largest coin that fits; a zero remainder maps to the 1-unit
    // code, which is harmless because no coin is requested then.
    always_comb begin
        code = COIN_1;
        if (change >= 7'd20) begin
            code = COIN_20;
        end else if (change >= 7'd10) begin
            code = COIN_10;
        end else if (change >= 7'd5) begin
            code = COIN_5;
        end
        value = coin_value(code);
    end

endmodule
`default_nettype wire

// File: rtl/vend_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispenser
// Purpose  : Delivery side of the vending machine. Accepts one sale record,
//            releases items one at a time over item_req/item_ack, pays change
//            greedily over coin_req/coin_ack, then pulses done. A missing
//            acknowledge within TIMEOUT_CYCLES parks the block in a sticky
//            jam state until reset.
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,  // 2..255
    parameter int unsigned GAP_CYCLES     = 2    // 0..256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sale_valid,
    output logic                sale_ready,
    input  logic [c_type_w-1:0] sale_type,
    input  logic [3:0]          sale_amount,
    input  logic [6:0]          sale_change,
    output logic                item_req,
    output logic [c_type_w-1:0] item_type,
    input  logic                item_ack,
    output logic                coin_req,
    output logic [1:0]          coin_code,
    input  logic                coin_ack,
    output logic                busy,
    output logic                done,
    output logic                error
);

    // Last timer value before a request is declared jammed, and last gap count
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] c_gap_last     = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t              r_state;
    logic [c_type_w-1:0] r_type;
    logic [3:0]          r_items;
    logic [6:0]          r_change;
    logic [7:0]          r_timer;
    logic                r_sale_ready;
    logic                r_item_req;
    logic                r_coin_req;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic [1:0]          w_pick_code;
    logic [6:0]          w_pick_value;
    logic [3:0]          w_items_left;
    logic [6:0]          w_change_left;
    logic                w_timer_expired;

    change_picker u_change_picker (
        .change (r_change),
        .code   (w_pick_code),
        .value  (w_pick_value)
    );

    // The greedy pick never exceeds the remainder, so this cannot underflow
    assign w_change_left   = r_change - w_pick_value;
    assign w_items_left    = r_items - 4'd1;
    assign w_timer_expired = (r_timer == c_timeout_last);

    // Sequencer: state, latched sale record, handshake timer and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_type       <= '0;
            r_items      <= '0;
            r_change     <= '0;
            r_timer      <= '0;
            r_sale_ready <= 1'b0;
            r_item_req   <= 1'b0;
            r_coin_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sale_ready && sale_valid) begin
                        r_type       <= sale_type;
                        r_items      <= sale_amount;
                        r_change     <= sale_change;
                        r_timer      <= '0;
                        r_sale_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        if (sale_amount != 4'd0) begin
                            r_state    <= ITEM;
                            r_item_req <= 1'b1;
                        end else if (sale_change != 7'd0) begin
                            r_state    <= COIN;
                            r_coin_req <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_sale_ready <= 1'b1;
                    end
                end

                ITEM: begin
                    if (!r_item_req) begin
                        // Single low cycle between back-to-back items
                        r_item_req <= 1'b1;
                    end else if (item_ack) begin
                        r_items    <= w_items_left;
                        r_timer    <= '0;
                        r_item_req <= 1'b0;
                        if (w_items_left != 4'd0) begin
                            if (GAP_CYCLES > 0) begin
                                r_state <= GAP;
                            end
                        end else if (r_change != 7'd0) begin
                            r_state    <= COIN;
                            r_coin_req <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_timer_expired) begin
                        r_state    <= JAM;
                        r_item_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                GAP: begin
                    if (r_timer == c_gap_last) begin
                        r_state    <= ITEM;
                        r_item_req <= 1'b1;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                COIN: begin
                    if (coin_ack) begin
                        r_change <= w_change_left;
                        r_timer  <= '0;
                        if (w_change_left == 7'd0) begin
                            r_state    <= DONE;
                            r_coin_req <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end else if (w_timer_expired) begin
                        r_state    <= JAM;
                        r_coin_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                DONE: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_sale_ready <= 1'b1;
                end

                JAM: begin
                    // Sticky until reset; sale record stays frozen for inspection
                    r_state <= JAM;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sale_ready = r_sale_ready;
    assign item_req   = r_item_req;
    assign item_type  = r_item_req ? r_type : '0;
    assign coin_req   = r_coin_req;
    assign coin_code  = r_coin_req ? w_pick_code : 2'd0;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispenser
// Purpose  : Directed self-checking bench for vend_dispenser. A transaction
//            model lists the item and coin handshakes each sale must produce;
//            a per-cycle compare process checks the DUT against it, and each
//            directed case pins timing with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sale_valid = 1'b0;
    logic       sale_ready;
    logic [2:0] sale_type = '0;
    logic [3:0] sale_amount = '0;
    logic [6:0] sale_change = '0;
    logic       item_req;
    logic [2:0] item_type;
    logic       item_ack = 1'b0;
    logic       coin_req;
    logic [1:0] coin_code;
    logic       coin_ack = 1'b0;
    logic       busy;
    logic       done;
    logic       error;

    always #5 clk = ~clk;

    vend_dispenser #(
        .TIMEOUT_CYCLES (16),
        .GAP_CYCLES     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sale_valid  (sale_valid),
        .sale_ready  (sale_ready),
        .sale_type   (sale_type),
        .sale_amount (sale_amount),
        .sale_change (sale_change),
        .item_req    (item_req),
        .item_type   (item_type),
        .item_ack    (item_ack),
        .coin_req    (coin_req),
        .coin_code   (coin_code),
        .coin_ack    (coin_ack),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Expected handshake transactions: items first, then coins
    typedef struct {
        bit is_coin;
        int val;
    } exp_t;
    exp_t exp_q[$];
    bit   model_on = 1'b0;

    task automatic model_sale(input int t, input int amt, input int chg);
        int den[4];
        int rem;
        den = '{1, 5, 10, 20};
        for (int i = 0; i < amt; i++) exp_q.push_back('{1'b0, t});
        rem = chg;
        while (rem > 0) begin
            for (int k = 3; k >= 0; k--) begin
                if (den[k] <= rem) begin
                    exp_q.push_back('{1'b1, k});
                    rem -= den[k];
                    break;
                end
            end
        end
    endtask

    // Observation logs
    int item_rise[$];
    int coin_log[$];
    int item_acc_cnt = 0;
    int item_hi_cnt  = 0;
    int coin_hi_cnt  = 0;
    int done_count   = 0;

    // Mechanism responder: acks one cycle after seeing a req, never twice in a row
    bit ack_item_en = 1'b1;
    bit ack_coin_en = 1'b1;
    initial begin
        bit pi, pa, pc, pca;
        forever begin
            @(negedge clk);
            pi = item_req; pa = item_ack; pc = coin_req; pca = coin_ack;
            @(posedge clk);
            #1;
            item_ack = ack_item_en && pi && !pa;
            coin_ack = ack_coin_en && pc && !pca;
        end
    end

    // Per-cycle compare against the transaction model, plus logging
    initial begin
        bit prev_item = 1'b0;
        bit ok;
        forever begin
            @(negedge clk);
            if (item_req && !prev_item) item_rise.push_back(cyc);
            prev_item = item_req;
            if (item_req) item_hi_cnt++;
            if (coin_req) coin_hi_cnt++;
            if (item_req && item_ack) item_acc_cnt++;
            if (coin_req && coin_ack) coin_log.push_back(int'(coin_code));
            if (done) done_count++;

            if (model_on && !rst) begin
                chk("req_exclusive", int'(item_req && coin_req), 0);
                chk("error_low", int'(error), 0);
                chk("ready_vs_busy", int'(sale_ready && busy), 0);
                if (item_req) begin
                    ok = (exp_q.size() > 0) && !exp_q[0].is_coin;
                    chk("item_req_expected", int'(ok), 1);
                    if (ok) begin
                        chk("item_type", int'(item_type), exp_q[0].val);
                        if (item_ack) void'(exp_q.pop_front());
                    end
                end
                if (coin_req) begin
                    ok = (exp_q.size() > 0) && exp_q[0].is_coin;
                    chk("coin_req_expected", int'(ok), 1);
                    if (ok) begin
                        chk("coin_code", int'(coin_code), exp_q[0].val);
                        if (coin_ack) void'(exp_q.pop_front());
                    end
                end
                if (done) begin
                    chk("done_all_handshakes", exp_q.size(), 0);
                    chk("done_busy", int'(busy), 1);
                end
            end
        end
    end

    task automatic clear_logs();
        @(posedge clk);
        #1;
        item_rise.delete();
        coin_log.delete();
        item_acc_cnt = 0;
        item_hi_cnt  = 0;
        coin_hi_cnt  = 0;
    endtask

    task automatic do_sale(input int t, input int a, input int c, output int acc);
        model_sale(t, a, c);
        @(posedge clk);
        #1;
        sale_valid  = 1'b1;
        sale_type   = 3'(t);
        sale_amount = 4'(a);
        sale_change = 7'(c);
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sale_ready) begin
                acc = cyc;
                break;
            end
        end
        chk("sale_accepted", int'(acc >= 0), 1);
        @(posedge clk);
        #1;
        sale_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        chk("done_seen", int'(dc >= 0), 1);
    endtask

    initial begin
        int acc, dc, jc, dc0;
        int exp_codes[9];
        exp_codes = '{3, 3, 3, 3, 3, 3, 1, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sale_ready", int'(sale_ready), 0);
        chk("rst_item_req", int'(item_req), 0);
        chk("rst_coin_req", int'(coin_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_item_type", int'(item_type), 0);
        chk("rst_coin_code", int'(coin_code), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", int'(sale_ready), 1);
        chk("busy_idle", int'(busy), 0);
        model_on = 1'b1;

        // One item of type 3, change 5
        clear_logs();
        do_sale(3, 1, 5, acc);
        wait_done(60, dc);
        chk("t1_latency", dc - acc, 5);
        chk("t1_items", item_acc_cnt, 1);
        chk("t1_coin_count", coin_log.size(), 1);
        if (coin_log.size() > 0) chk("t1_coin_code", coin_log[0], 1);
        @(negedge clk);
        chk("t1_done_pulse_width", int'(done), 0);
        chk("t1_ready_again", int'(sale_ready), 1);

        // Three items, no change, gap of two
        clear_logs();
        do_sale(5, 3, 0, acc);
        wait_done(80, dc);
        chk("t2_latency", dc - acc, 11);
        chk("t2_items", item_acc_cnt, 3);
        chk("t2_req_bursts", item_rise.size(), 3);
        if (item_rise.size() == 3) begin
            chk("t2_first_req", item_rise[0] - acc, 1);
            chk("t2_spacing_1", item_rise[1] - item_rise[0], 4);
            chk("t2_spacing_2", item_rise[2] - item_rise[1], 4);
        end
        chk("t2_no_coin_req", coin_hi_cnt, 0);

        // Worst-case change
        clear_logs();
        do_sale(0, 0, 127, acc);
        wait_done(100, dc);
        chk("t3_latency", dc - acc, 19);
        chk("t3_coin_count", coin_log.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < coin_log.size()) chk($sformatf("t3_code_%0d", i), coin_log[i], exp_codes[i]);
        end
        chk("t3_no_item_req", item_hi_cnt, 0);

        // Empty sale
        clear_logs();
        do_sale(6, 0, 0, acc);
        wait_done(20, dc);
        chk("t4_latency", dc - acc, 1);
        chk("t4_no_item_req", item_hi_cnt, 0);
        chk("t4_no_coin_req", coin_hi_cnt, 0);

        // Reset in the middle of paying change
        clear_logs();
        do_sale(2, 0, 40, acc);
        repeat (2) @(posedge clk);
        #1;
        model_on = 1'b0;
        rst = 1'b1;
        dc0 = done_count;
        @(posedge clk);
        @(negedge clk);
        chk("t5_coins_before_rst", coin_log.size(), 1);
        chk("t5_item_req", int'(item_req), 0);
        chk("t5_coin_req", int'(coin_req), 0);
        chk("t5_coin_code", int'(coin_code), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_sale_ready", int'(sale_ready), 0);
        chk("t5_error", int'(error), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("t5_no_done_after_rst", done_count, dc0);
        model_on = 1'b1;
        clear_logs();
        do_sale(1, 1, 1, acc);
        wait_done(60, dc);
        chk("t5_resale_latency", dc - acc, 5);
        chk("t5_resale_coin_count", coin_log.size(), 1);

        // Item never acknowledged -> jam
        clear_logs();
        model_on = 1'b0;
        ack_item_en = 1'b0;
        do_sale(4, 2, 0, acc);
        exp_q.delete();
        jc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (error) begin
                jc = cyc;
                break;
            end
        end
        chk("t6_jam_seen", int'(jc >= 0), 1);
        chk("t6_jam_cycle", jc - acc, 17);
        chk("t6_req_cycles", item_hi_cnt, 16);
        chk("t6_item_req", int'(item_req), 0);
        chk("t6_coin_req", int'(coin_req), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        @(posedge clk);
        #1 sale_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_ready_blocked", int'(sale_ready), 0);
            chk("t6_error_sticky", int'(error), 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        sale_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_error_cleared", int'(error), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_item_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_ready_after_rst", int'(sale_ready), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Output side of the vending machine: takes one completed sale and drives the delivery mechanism.
- The sale record is product type, item count and change owed, as produced by the sale-side logic in Main.
- Releases items one at a time over a req/ack handshake, then pays change coin by coin with greedy denominations.
- Reports completion with `done`, or a sticky jam error if the mechanism fails to acknowledge in time.

Parameters:
- TIMEOUT_CYCLES, 16: cycles a req may stay unacknowledged before JAM; valid range 2..255.
- GAP_CYCLES, 2: idle cycles between consecutive item requests; 0 allowed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sale_valid  in  1  sale record present.
- sale_ready  out  1  block can accept a sale.
- sale_type  in  3  product type (0..7).
- sale_amount  in  4  items to dispense (0..15).
- sale_change  in  7  change owed in money units (0..127).
- item_req  out  1  request release of one item.
- item_type  out  3  type for the current item_req.
- item_ack  in  1  mechanism released the item.
- coin_req  out  1  request ejection of one coin.
- coin_code  out  2  coin denomination: 0=1, 1=5, 2=10, 3=20.
- coin_ack  in  1  coin ejected.
- busy  out  1  sale in progress (any state other than IDLE and JAM).
- done  out  1  one-cycle pulse when a sale is finished.
- error  out  1  sticky jam flag.

Behaviour:
- Reset: all outputs 0, state IDLE, latched registers cleared. sale_ready rises in the first cycle after rst deasserts. rst in any state aborts at once: no done, error cleared.
- States: IDLE, ITEM, GAP, COIN, DONE, JAM.
- IDLE:
  - sale_ready=1.
  - On sale_valid&&sale_ready, latch type/amount/change in that cycle.
  - Next state: ITEM if amount>0; else COIN if change>0; else DONE.
  - sale_valid while not ready is ignored; no buffering.
- ITEM:
  - item_req=1, item_type=latched type, timer increments each cycle.
  - item_ack in a cycle with item_req=1: remaining--, timer cleared.
  - Next state after ack: GAP if remaining>0 and GAP_CYCLES>0; ITEM if remaining>0 and GAP_CYCLES=0 (req drops for exactly one cycle); otherwise COIN if change>0, else DONE.
- GAP: item_req=0 for GAP_CYCLES cycles, then ITEM.
- COIN:
  - coin_req=1.
  - coin_code is the largest denomination ≤ remaining change, recomputed from the registered remainder.
  - On coin_ack: change -= denomination. Next cycle is another COIN (req stays high, code may change) while change>0; otherwise DONE.
- Timeout: in ITEM or COIN, if the timer reaches TIMEOUT_CYCLES with no ack, go to JAM.
  - An ack arriving in the same cycle the timer reaches the limit counts as success.
- DONE: done=1 for one cycle, then IDLE. sale_ready=0 during DONE.
- JAM:
  - error=1, all reqs 0, sale_ready=0, busy=0.
  - Held until rst.
  - Remaining counts are frozen, readable only in simulation.
- Ack rules:
  - item_ack/coin_ack while the matching req is low are ignored.
  - coin_ack during ITEM and item_ack during COIN are ignored.
- Arithmetic: change held in a 7-bit register, subtraction never underflows by construction of the greedy choice. Item remainder is 4 bits.
- Worst case change 127 = 6×20 + 5 + 1 + 1 = 9 coins.
- Latency: with immediate acks, a 1-item, 0-change sale gives done 3 cycles after acceptance (ITEM, ack, DONE).

Decomposition:
- Package vend_pkg:
  - state enum.
  - coin code constants: COIN_1=0, COIN_5=1, COIN_10=2, COIN_20=3.
  - denomination value function (code → 7-bit value).
  - product-type width constant (3), shared with Main.
- Sub-module change_picker: combinational, remaining change in → coin_code and value out. Keeps the greedy logic testable on its own.

Test Plan:
- Sale type=3, amount=1, change=5, acks 1 cycle after each req:
  - one item_req with item_type=3, then one coin_req with code 1, then a done pulse.
  - error=0 throughout.
- Sale amount=3, change=0, GAP_CYCLES=2:
  - exactly three item_ack-accepted reqs, each separated by 2 low cycles.
  - no coin_req, then done.
- Sale amount=0, change=127:
  - coin codes in order 3,3,3,3,3,3,1,0,0.
  - done after the 9th ack.
- Sale amount=0, change=0: done pulse in the cycle after acceptance; no reqs.
- Sale amount=2 with item_ack never asserted:
  - item_req high for TIMEOUT_CYCLES=16 cycles, then JAM with error=1 and reqs 0.
  - sale_valid stays unaccepted until rst.
- rst asserted mid-COIN with change remaining:
  - next cycle all outputs 0 and no done.
  - a new sale afterwards completes normally.
